// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the system-control transmit path.
package sys_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_BYTE = 3'd1,
    ALU_LO  = 3'd2,
    ALU_HI  = 3'd3,
    HDR     = 3'd4
  } state_t;

  typedef enum logic {
    GNT_RD  = 1'b0,
    GNT_ALU = 1'b1
  } grant_t;

  localparam logic [7:0] HDR_RD  = 8'hBB;
  localparam logic [7:0] HDR_ALU = 8'hDD;

endpackage

// File: rtl/sys_ctrl_tx_arb_if.sv
// Bundle of source strobes, UART TX handshake and status flags.
interface sys_ctrl_tx_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  RD_D_VLD;
  logic [ALU_WIDTH-1:0]  ALU_OUT;
  logic                  ALU_OUT_VLD;
  logic                  TX_RDY;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  CTRL_BUSY;
  logic                  RD_OVF;
  logic                  ALU_OVF;

  modport master (
    input  RD_DATA, RD_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_RDY,
    output TX_P_DATA, TX_D_VLD, CTRL_BUSY, RD_OVF, ALU_OVF
  );

  modport slave (
    output RD_DATA, RD_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_RDY,
    input  TX_P_DATA, TX_D_VLD, CTRL_BUSY, RD_OVF, ALU_OVF
  );
endinterface

// File: rtl/sys_ctrl_tx_slot.sv
// One-deep holding slot with pending flag and sticky overflow.
module sys_ctrl_tx_slot #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_take,
  output logic [WIDTH-1:0] o_data,
  output logic             o_pend,
  output logic             o_ovf
);
  logic [WIDTH-1:0] r_data;
  logic             r_pend;
  logic             r_ovf;
  logic             w_free;

  // A slot being taken this cycle can accept a new strobe in the same cycle.
  assign w_free = ~r_pend | i_take;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= {WIDTH{1'b0}};
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (i_vld & w_free) begin
        r_data <= i_data;
        r_pend <= 1'b1;
      end else if (i_take) begin
        r_pend <= 1'b0;
      end
      if (i_vld & ~w_free) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_data = r_data;
  assign o_pend = r_pend;
  assign o_ovf  = r_ovf;
endmodule

// File: rtl/sys_ctrl_tx_arb.sv
// Round-robin arbiter and byte serialiser feeding the UART TX.
// Define SYS_CTRL_TX_HDR_EN to prefix each frame with a source header byte.
module sys_ctrl_tx_arb
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
) (
  input logic               CLK,
  input logic               RST,
  sys_ctrl_tx_arb_if.master bus
);
  state_t                r_state, w_state_nxt;
  grant_t                r_last_grant, w_last_grant_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_nxt;
  logic                  r_tx_vld, w_tx_vld_nxt;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_hold_hi, w_hold_hi_nxt;
`ifdef SYS_CTRL_TX_HDR_EN
  logic [DATA_WIDTH-1:0] r_hold_lo, w_hold_lo_nxt;
`endif
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [ALU_WIDTH-1:0]  w_alu_data;
  logic w_rd_pend, w_alu_pend, w_rd_take, w_alu_take, w_rd_ovf, w_alu_ovf;
  logic w_xfer, w_pick_rd, w_rd_pend_nxt, w_alu_pend_nxt;

  sys_ctrl_tx_slot #(.WIDTH(DATA_WIDTH)) u_rd_slot (
    .i_clk(CLK), .i_rst(RST), .i_vld(bus.RD_D_VLD), .i_data(bus.RD_DATA),
    .i_take(w_rd_take), .o_data(w_rd_data), .o_pend(w_rd_pend), .o_ovf(w_rd_ovf)
  );

  sys_ctrl_tx_slot #(.WIDTH(ALU_WIDTH)) u_alu_slot (
    .i_clk(CLK), .i_rst(RST), .i_vld(bus.ALU_OUT_VLD), .i_data(bus.ALU_OUT),
    .i_take(w_alu_take), .o_data(w_alu_data), .o_pend(w_alu_pend), .o_ovf(w_alu_ovf)
  );

  assign w_xfer = r_tx_vld & bus.TX_RDY;
  // last_grant only moves on a genuine tie, so a lone grant never shifts priority.
  assign w_pick_rd      = w_rd_pend & (~w_alu_pend | (r_last_grant == GNT_ALU));
  assign w_rd_pend_nxt  = bus.RD_D_VLD | (w_rd_pend & ~w_rd_take);
  assign w_alu_pend_nxt = bus.ALU_OUT_VLD | (w_alu_pend & ~w_alu_take);

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_tx_data_nxt    = r_tx_data;
    w_tx_vld_nxt     = r_tx_vld;
    w_hold_hi_nxt    = r_hold_hi;
`ifdef SYS_CTRL_TX_HDR_EN
    w_hold_lo_nxt    = r_hold_lo;
`endif
    w_rd_take        = 1'b0;
    w_alu_take       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rd_pend | w_alu_pend) begin
          w_tx_vld_nxt = 1'b1;
          if (w_rd_pend & w_alu_pend) begin
            w_last_grant_nxt = w_pick_rd ? GNT_RD : GNT_ALU;
          end else begin
            w_last_grant_nxt = r_last_grant;
          end
          if (w_pick_rd) begin
            w_rd_take = 1'b1;
`ifdef SYS_CTRL_TX_HDR_EN
            w_state_nxt   = HDR;
            w_tx_data_nxt = DATA_WIDTH'(HDR_RD);
            w_hold_lo_nxt = w_rd_data;
`else
            w_state_nxt   = RD_BYTE;
            w_tx_data_nxt = w_rd_data;
`endif
          end else begin
            w_alu_take    = 1'b1;
            w_hold_hi_nxt = w_alu_data[ALU_WIDTH-1:DATA_WIDTH];
`ifdef SYS_CTRL_TX_HDR_EN
            w_state_nxt   = HDR;
            w_tx_data_nxt = DATA_WIDTH'(HDR_ALU);
            w_hold_lo_nxt = w_alu_data[DATA_WIDTH-1:0];
`else
            w_state_nxt   = ALU_LO;
            w_tx_data_nxt = w_alu_data[DATA_WIDTH-1:0];
`endif
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
`ifdef SYS_CTRL_TX_HDR_EN
      // The header byte still in the output register tells which payload follows.
      HDR: begin
        if (w_xfer) begin
          w_tx_data_nxt = r_hold_lo;
          w_state_nxt   = (r_tx_data == DATA_WIDTH'(HDR_ALU)) ? ALU_LO : RD_BYTE;
        end else begin
          w_state_nxt = HDR;
        end
      end
`endif
      RD_BYTE: begin
        if (w_xfer) begin
          w_state_nxt  = IDLE;
          w_tx_vld_nxt = 1'b0;
        end else begin
          w_state_nxt = RD_BYTE;
        end
      end
      ALU_LO: begin
        if (w_xfer) begin
          w_state_nxt   = ALU_HI;
          w_tx_data_nxt = r_hold_hi;
        end else begin
          w_state_nxt = ALU_LO;
        end
      end
      ALU_HI: begin
        if (w_xfer) begin
          w_state_nxt  = IDLE;
          w_tx_vld_nxt = 1'b0;
        end else begin
          w_state_nxt = ALU_HI;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_tx_vld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_ALU;
      r_tx_data    <= {DATA_WIDTH{1'b0}};
      r_tx_vld     <= 1'b0;
      r_busy       <= 1'b0;
      r_hold_hi    <= {DATA_WIDTH{1'b0}};
`ifdef SYS_CTRL_TX_HDR_EN
      r_hold_lo    <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_vld     <= w_tx_vld_nxt;
      r_busy       <= (w_state_nxt != IDLE) | w_rd_pend_nxt | w_alu_pend_nxt;
      r_hold_hi    <= w_hold_hi_nxt;
`ifdef SYS_CTRL_TX_HDR_EN
      r_hold_lo    <= w_hold_lo_nxt;
`endif
    end
  end

  assign bus.TX_P_DATA = r_tx_data;
  assign bus.TX_D_VLD  = r_tx_vld;
  assign bus.CTRL_BUSY = r_busy;
  assign bus.RD_OVF    = w_rd_ovf;
  assign bus.ALU_OVF   = w_alu_ovf;
endmodule

// File: tb/tb_sys_ctrl_tx_arb.sv
// Bench for sys_ctrl_tx_arb: vector table plus scoreboard of expected TX bytes.
module tb_sys_ctrl_tx_arb;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sys_ctrl_tx_arb_if #(.DATA_WIDTH(8), .ALU_WIDTH(16)) bus ();
  sys_ctrl_tx_arb #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic            rd_v;
    logic [7:0]      rd;
    logic            alu_v;
    logic [15:0]     alu;
    int              n;
    logic [5:0][7:0] exp;
  } vec_t;

  vec_t       tbl [7];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb_q [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock; a byte accepted at the coming edge is popped and compared mid-cycle.
  task automatic tick();
    logic [7:0] e;
    @(negedge CLK);
    if (!RST && bus.TX_D_VLD && bus.TX_RDY) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got %h expected none", bus.TX_P_DATA);
      end else begin
        e = sb_q.pop_front();
        chk("tx_byte", 16'(bus.TX_P_DATA), 16'(e));
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.RD_D_VLD = 1'b0;
    bus.ALU_OUT_VLD = 1'b0;
    bus.TX_RDY = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    sb_q.delete();
  endtask

  task automatic strobe(input logic rv, input logic [7:0] r, input logic av, input logic [15:0] a);
    bus.RD_D_VLD = rv;
    bus.RD_DATA = r;
    bus.ALU_OUT_VLD = av;
    bus.ALU_OUT = a;
    tick();
    bus.RD_D_VLD = 1'b0;
    bus.ALU_OUT_VLD = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((sb_q.size() != 0 || bus.CTRL_BUSY) && k < 100) begin
      tick();
      k++;
    end
    chk({name, "_q_empty"}, 16'(sb_q.size()), 16'd0);
    chk({name, "_busy"}, 16'(bus.CTRL_BUSY), 16'd0);
  endtask

  function automatic vec_t mk(input logic rv, input logic [7:0] r, input logic av, input logic [15:0] a);
    vec_t v;
    v.rd_v = rv;
    v.rd = r;
    v.alu_v = av;
    v.alu = a;
    v.n = 0;
    v.exp = '0;
    return v;
  endfunction

  function automatic vec_t add_rd(input vec_t vi, input logic [7:0] b);
    vec_t v = vi;
`ifdef SYS_CTRL_TX_HDR_EN
    v.exp[v.n] = 8'hBB;
    v.n++;
`endif
    v.exp[v.n] = b;
    v.n++;
    return v;
  endfunction

  function automatic vec_t add_alu(input vec_t vi, input logic [15:0] w);
    vec_t v = vi;
`ifdef SYS_CTRL_TX_HDR_EN
    v.exp[v.n] = 8'hDD;
    v.n++;
`endif
    v.exp[v.n] = w[7:0];
    v.n++;
    v.exp[v.n] = w[15:8];
    v.n++;
    return v;
  endfunction

  initial begin
    bus.RD_DATA = 8'h00;
    bus.ALU_OUT = 16'h0000;
    // Expected byte streams in transmit order; ties alternate starting with RD after reset.
    tbl[0] = add_rd(mk(1'b1, 8'h3C, 1'b0, 16'h0000), 8'h3C);
    tbl[1] = add_alu(mk(1'b0, 8'h00, 1'b1, 16'hBEEF), 16'hBEEF);
    tbl[2] = add_alu(add_rd(mk(1'b1, 8'h11, 1'b1, 16'h2233), 8'h11), 16'h2233);
    tbl[3] = add_rd(add_alu(mk(1'b1, 8'h44, 1'b1, 16'h5566), 16'h5566), 8'h44);
    tbl[4] = add_rd(mk(1'b1, 8'hA5, 1'b0, 16'h0000), 8'hA5);
    tbl[5] = add_alu(mk(1'b0, 8'h00, 1'b1, 16'h0000), 16'h0000);
    tbl[6] = add_alu(add_rd(mk(1'b1, 8'hFF, 1'b1, 16'hFF01), 8'hFF), 16'hFF01);

    do_reset();
    chk("rst_data", 16'(bus.TX_P_DATA), 16'h0000);
    chk("rst_vld", 16'(bus.TX_D_VLD), 16'h0000);
    chk("rst_busy", 16'(bus.CTRL_BUSY), 16'h0000);
    chk("rst_rd_ovf", 16'(bus.RD_OVF), 16'h0000);
    chk("rst_alu_ovf", 16'(bus.ALU_OVF), 16'h0000);

`ifdef SYS_CTRL_TX_HDR_EN
    sb_q.push_back(8'hBB);
    sb_q.push_back(8'h3C);
    strobe(1'b1, 8'h3C, 1'b0, 16'h0000);
    tick();
    chk("hdr_vld", 16'(bus.TX_D_VLD), 16'h0001);
    chk("hdr_byte", 16'(bus.TX_P_DATA), 16'h00BB);
    tick();
    chk("hdr_payload", 16'(bus.TX_P_DATA), 16'h003C);
    drain("hdr");
`else
    // Single read: valid two cycles after the strobe, one byte, then idle.
    sb_q.push_back(8'h3C);
    strobe(1'b1, 8'h3C, 1'b0, 16'h0000);
    chk("rd_c1_vld", 16'(bus.TX_D_VLD), 16'h0000);
    chk("rd_c1_busy", 16'(bus.CTRL_BUSY), 16'h0001);
    tick();
    chk("rd_c2_vld", 16'(bus.TX_D_VLD), 16'h0001);
    chk("rd_c2_data", 16'(bus.TX_P_DATA), 16'h003C);
    tick();
    chk("rd_c3_vld", 16'(bus.TX_D_VLD), 16'h0000);
    chk("rd_c3_busy", 16'(bus.CTRL_BUSY), 16'h0000);

    // ALU result: low byte then high byte with no gap.
    sb_q.push_back(8'hEF);
    sb_q.push_back(8'hBE);
    strobe(1'b0, 8'h00, 1'b1, 16'hBEEF);
    tick();
    chk("alu_lo_data", 16'(bus.TX_P_DATA), 16'h00EF);
    tick();
    chk("alu_hi_vld", 16'(bus.TX_D_VLD), 16'h0001);
    chk("alu_hi_data", 16'(bus.TX_P_DATA), 16'h00BE);
    tick();
    chk("alu_end_vld", 16'(bus.TX_D_VLD), 16'h0000);

    // Backpressure in ALU_LO holds the low byte.
    sb_q.push_back(8'hEF);
    sb_q.push_back(8'hBE);
    strobe(1'b0, 8'h00, 1'b1, 16'hBEEF);
    tick();
    bus.TX_RDY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_vld", 16'(bus.TX_D_VLD), 16'h0001);
      chk("bp_data", 16'(bus.TX_P_DATA), 16'h00EF);
    end
    bus.TX_RDY = 1'b1;
    tick();
    chk("bp_hi_data", 16'(bus.TX_P_DATA), 16'h00BE);
    tick();
    chk("bp_end_vld", 16'(bus.TX_D_VLD), 16'h0000);
`endif

    do_reset();
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < tbl[i].n; j++) sb_q.push_back(tbl[i].exp[j]);
      strobe(tbl[i].rd_v, tbl[i].rd, tbl[i].alu_v, tbl[i].alu);
      drain($sformatf("vec%0d", i));
    end

    // Overflow: second strobe lands in the cycle the slot is taken, third is dropped.
    do_reset();
    bus.TX_RDY = 1'b0;
    sb_q.push_back(8'h01);
    sb_q.push_back(8'h02);
    strobe(1'b1, 8'h01, 1'b0, 16'h0000);
    strobe(1'b1, 8'h02, 1'b0, 16'h0000);
    chk("ovf_rd_before", 16'(bus.RD_OVF), 16'h0000);
    chk("ovf_first_byte", 16'(bus.TX_P_DATA), 16'h0001);
    strobe(1'b1, 8'h03, 1'b0, 16'h0000);
    chk("ovf_rd_set", 16'(bus.RD_OVF), 16'h0001);
    repeat (5) tick();
    bus.TX_RDY = 1'b1;
    drain("ovf_rd");
    chk("ovf_rd_sticky", 16'(bus.RD_OVF), 16'h0001);
    chk("ovf_alu_clear", 16'(bus.ALU_OVF), 16'h0000);

    bus.TX_RDY = 1'b0;
    sb_q.push_back(8'h0B);
    sb_q.push_back(8'h0A);
    sb_q.push_back(8'h0D);
    sb_q.push_back(8'h0C);
    strobe(1'b0, 8'h00, 1'b1, 16'h0A0B);
    strobe(1'b0, 8'h00, 1'b1, 16'h0C0D);
    chk("ovf_alu_before", 16'(bus.ALU_OVF), 16'h0000);
    strobe(1'b0, 8'h00, 1'b1, 16'h0E0F);
    chk("ovf_alu_set", 16'(bus.ALU_OVF), 16'h0001);
    bus.TX_RDY = 1'b1;
    drain("ovf_alu");
    chk("ovf_alu_sticky", 16'(bus.ALU_OVF), 16'h0001);

`ifndef SYS_CTRL_TX_HDR_EN
    // Reset while the high byte is on offer: it must never be transferred.
    do_reset();
    chk("rst_clears_ovf", 16'(bus.RD_OVF), 16'h0000);
    sb_q.push_back(8'h34);
    strobe(1'b0, 8'h00, 1'b1, 16'h1234);
    tick();
    chk("mid_lo_data", 16'(bus.TX_P_DATA), 16'h0034);
    tick();
    chk("mid_hi_data", 16'(bus.TX_P_DATA), 16'h0012);
    RST = 1'b1;
    tick();
    chk("mid_rst_vld", 16'(bus.TX_D_VLD), 16'h0000);
    chk("mid_rst_data", 16'(bus.TX_P_DATA), 16'h0000);
    chk("mid_rst_busy", 16'(bus.CTRL_BUSY), 16'h0000);
    RST = 1'b0;
    repeat (5) tick();
    chk("mid_after_vld", 16'(bus.TX_D_VLD), 16'h0000);
    chk("mid_after_q", 16'(sb_q.size()), 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sys_ctrl_tx_arb.md
Name: sys_ctrl_tx_arb

Overview:
Transmit-side controller of the system control path. It captures register-file read responses and ALU results, arbitrates between them round-robin, and serialises each into bytes for the UART transmitter over a valid/ready handshake. ALU results are wider than one byte and go out LSB byte first. Each source has a one-deep holding slot, so a response arriving while the transmitter is busy is not lost.

Parameters:
DATA_WIDTH, 8, byte width of register-file data and of the UART TX parallel bus.
ALU_WIDTH, 16, ALU result width; must equal 2*DATA_WIDTH.

Ports:
CLK  in  1  system clock; all logic on rising edge.
RST  in  1  synchronous reset, active-high.
RD_DATA  in  DATA_WIDTH  register-file read data.
RD_D_VLD  in  1  one-cycle strobe; RD_DATA valid this cycle.
ALU_OUT  in  ALU_WIDTH  ALU result.
ALU_OUT_VLD  in  1  one-cycle strobe; ALU_OUT valid this cycle.
TX_RDY  in  1  UART TX can accept a byte this cycle.
TX_P_DATA  out  DATA_WIDTH  byte offered to the UART TX.
TX_D_VLD  out  1  TX_P_DATA valid; held until accepted.
CTRL_BUSY  out  1  high while any slot is pending or the FSM is not in IDLE.
RD_OVF  out  1  sticky flag: a register-file response was dropped.
ALU_OVF  out  1  sticky flag: an ALU result was dropped.

Behaviour:
- Reset (RST=1 at a CLK edge): FSM to IDLE; both slots empty; last_grant=ALU, so RD wins the first tie. All outputs 0: TX_P_DATA=0, TX_D_VLD=0, CTRL_BUSY=0, RD_OVF=0, ALU_OVF=0. Reset mid-transfer abandons the frame with no further bytes offered.
- Capture: RD_D_VLD with the RD slot empty loads rd_slot and sets rd_pend. A slot counts as empty in the cycle the FSM takes its data, so a same-cycle strobe is accepted. RD_D_VLD with the slot full: data dropped, RD_OVF set to 1. The ALU slot follows the same rules with ALU_OVF. RD_OVF and ALU_OVF clear only on reset.
- Transfer: a byte moves on a rising edge where TX_D_VLD=1 and TX_RDY=1. TX_P_DATA is stable while TX_D_VLD=1 and not accepted. All outputs are registered.
- FSM states: IDLE, RD_BYTE, ALU_LO, ALU_HI.
- IDLE:
  - Only rd_pend set: go to RD_BYTE.
  - Only alu_pend set: go to ALU_LO.
  - Both set: grant the source that is not last_grant; update last_grant.
  - On grant, copy the slot into the output register, clear the pend flag, and assert TX_D_VLD on the next cycle.
  - Minimum latency: input strobe to TX_D_VLD is 2 cycles.
- RD_BYTE: TX_P_DATA=rd data. On transfer, go to IDLE with TX_D_VLD=0.
- ALU_LO: TX_P_DATA=ALU[7:0]. On transfer, go to ALU_HI and present ALU[15:8] next cycle.
- ALU_HI: on transfer, go to IDLE.
- Frames never interleave; arbitration happens only in IDLE.
- TX_D_VLD drops for at least one cycle between frames (return through IDLE) and never between ALU_LO and ALU_HI.
- TX_RDY low holds the current state indefinitely; there is no timeout.
- Unused state encodings return to IDLE.

Optional Feature:
- Macro: SYS_CTRL_TX_HDR_EN.
- When defined: adds state HDR, entered from IDLE on grant. It sends a header byte before the payload: 8'hBB for a register-file response, 8'hDD for an ALU result. After the header, go to RD_BYTE or ALU_LO. Minimum inputs-to-payload latency grows by one byte transfer.
- When undefined: no HDR state and no header bytes; behaviour exactly as above.

Decomposition:
- Shared package sys_ctrl_pkg holds:
  - state localparams IDLE, RD_BYTE, ALU_LO, ALU_HI, HDR;
  - header constants HDR_RD=8'hBB, HDR_ALU=8'hDD;
  - the grant encoding (GNT_RD, GNT_ALU).
- One natural sub-module: sys_ctrl_tx_slot, a one-deep holding register with pend flag, take input and sticky overflow. It is instantiated twice (widths DATA_WIDTH and ALU_WIDTH). Arbitration and FSM stay in the top module.

Test Plan:
1. Single read: RD_DATA=8'h3C strobe, TX_RDY=1 → TX_D_VLD 2 cycles later, TX_P_DATA=8'h3C for one cycle; CTRL_BUSY returns to 0.
2. ALU result: ALU_OUT=16'hBEEF strobe, TX_RDY=1 → bytes 8'hEF then 8'hBE on consecutive cycles, with no gap between them.
3. Backpressure: TX_RDY=0 for 10 cycles during ALU_LO → TX_P_DATA holds 8'hEF and TX_D_VLD stays 1; raising TX_RDY completes 8'hEF then 8'hBE.
4. Tie: RD 8'h11 and ALU 16'h2233 strobed in the same cycle after reset → order 8'h11, 8'h33, 8'h22. Repeating with both again → ALU first (8'h33, 8'h22, 8'h11).
5. Overflow: TX_RDY=0; RD strobes 8'h01 (taken), 8'h02 (held in slot), 8'h03 (slot full) → RD_OVF=1 and stays 1. Output bytes are 8'h01 then 8'h02; 8'h03 never appears.
6. Reset mid-frame: assert RST while in ALU_HI → next cycle all outputs 0, no high byte sent. With SYS_CTRL_TX_HDR_EN defined, a read of 8'h3C emits 8'hBB then 8'h3C.
